// File: rtl/seq_divider_pkg.sv
// ============================================================================
// seq_divider_pkg : shared ALU divider types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] INT_MIN   = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// seq_divider_if : start/busy/done handshake between execute stage and divider
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider_cond_negate.sv
// ============================================================================
// seq_divider_cond_negate : two's-complement negate when ctrl is set
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider_cond_negate
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic [WIDTH-1:0] value,
    input  wire logic             ctrl,
    output logic      [WIDTH-1:0] result
);

    assign result = (value ^ {WIDTH{ctrl}}) + {{(WIDTH-1){1'b0}}, ctrl};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : fixed-latency radix-2 restoring divider, signed or unsigned
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 8 || (WIDTH % 2) != 0 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
            $error("seq_divider: unsupported WIDTH/CNT_W combination");
        end
    endgenerate

    div_state_t       r_state;
    div_state_t       w_next;
    logic             w_busy;
    logic             w_done;

    logic             r_is_signed;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_n;
    logic             r_sign_d;
    logic             r_dz;
    logic             r_ov;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic             w_sign_n;
    logic             w_sign_d;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;

    assign w_sign_n = r_is_signed & r_dividend[WIDTH-1];
    assign w_sign_d = r_is_signed & r_divisor[WIDTH-1];

    seq_divider_cond_negate #(.WIDTH(WIDTH)) u_neg_dvd (
        .value(r_dividend), .ctrl(w_sign_n), .result(w_dvd_mag)
    );
    seq_divider_cond_negate #(.WIDTH(WIDTH)) u_neg_dvs (
        .value(r_divisor), .ctrl(w_sign_d), .result(w_dvs_mag)
    );
    seq_divider_cond_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .value(r_quo), .ctrl(r_sign_n ^ r_sign_d), .result(w_quo_fix)
    );
    seq_divider_cond_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .value(r_rem), .ctrl(r_sign_n), .result(w_rem_fix)
    );

    // rem < |divisor| holds each step, so the WIDTH+1-bit difference never
    // wraps and its top bit is the borrow.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs_mag};
    assign w_borrow = w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? PREP : IDLE;
            PREP:    w_next = ITER;
            ITER:    w_next = (r_cnt == C_LAST) ? FIXUP : ITER;
            FIXUP:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_signed   <= 1'b0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_dvs_mag     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_cnt         <= '0;
            r_sign_n      <= 1'b0;
            r_sign_d      <= 1'b0;
            r_dz          <= 1'b0;
            r_ov          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_is_signed <= bus.is_signed;
                        r_dividend  <= bus.dividend;
                        r_divisor   <= bus.divisor;
                    end
                end
                PREP: begin
                    r_sign_n  <= w_sign_n;
                    r_sign_d  <= w_sign_d;
                    r_quo     <= w_dvd_mag;
                    r_dvs_mag <= w_dvs_mag;
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_dz      <= (r_divisor == '0);
                    r_ov      <= r_is_signed && (r_dividend == C_INT_MIN) && (r_divisor == C_ALL_ONES);
                end
                ITER: begin
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_rem <= w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIXUP: begin
                    r_div_by_zero <= r_dz;
                    r_overflow    <= r_ov;
                    if (r_dz) begin
                        r_quotient  <= C_ALL_ONES;
                        r_remainder <= r_dividend;
                    end else if (r_ov) begin
                        r_quotient  <= C_INT_MIN;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= w_quo_fix;
                        r_remainder <= w_rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : scoreboard bench for seq_divider against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   ncnt = 0;
    int   t0 = 0;
    logic prev_busy = 1'b0;
    logic idle_next = 1'b0;
    logic mon_en = 1'b0;

    function automatic exp_t ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint x, y, q, r;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sg && a == INT_MIN && b == 32'hFFFF_FFFF) begin
            e.q  = INT_MIN;
            e.r  = 32'd0;
            e.ov = 1'b1;
        end else begin
            if (sg) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'd0, a});
                y = longint'({32'd0, b});
            end
            q = x / y;
            r = x % y;
            e.q = q[31:0];
            e.r = r[31:0];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse; between pulses
    // the outputs must hold the last delivered result.
    always @(negedge clk) begin
        ncnt++;
        if (mon_en) begin
            if (bus.busy && !prev_busy) t0 = ncnt;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 expected no pending operation");
                end else begin
                    mon_e = sb.pop_front();
                    chk("quotient", 66'(bus.quotient), 66'(mon_e.q));
                    chk("remainder", 66'(bus.remainder), 66'(mon_e.r));
                    chk("div_by_zero", 66'(bus.div_by_zero), 66'(mon_e.dz));
                    chk("overflow", 66'(bus.overflow), 66'(mon_e.ov));
                    chk("latency", 66'(ncnt - t0), 66'(34));
                    chk("busy_at_done", 66'(bus.busy), 66'(1));
                    held = mon_e;
                end
                idle_next = 1'b1;
            end else begin
                chk("held_outputs",
                    {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow},
                    {held.q, held.r, held.dz, held.ov});
                if (idle_next) begin
                    chk("busy_after_done", 66'(bus.busy), 66'(0));
                    idle_next = 1'b0;
                end
            end
        end
        prev_busy = bus.busy;
    end

    task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got busy=1 expected idle within 200 cycles");
        end else begin
            bus.start     = 1'b1;
            bus.is_signed = sg;
            bus.dividend  = a;
            bus.divisor   = b;
            sb.push_back(ref_div(sg, a, b));
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || bus.busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d busy=%0b expected 0 0", sb.size(), bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_busy"}, 66'(bus.busy), 66'(0));
        chk({nm, "_done"}, 66'(bus.done), 66'(0));
        chk({nm, "_outputs"},
            {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 66'(0));
    endtask

    initial begin
        logic [31:0] a, b;
        bit          sg;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        held          = '{32'd0, 32'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases, issued back-to-back so each result must hold
        // through the next operation's PREP and ITER cycles.
        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        issue(1'b1, 32'h1234_5678, 32'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // A start pulse mid-operation must be dropped.
        issue(1'b0, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();

        // Reset in the middle of ITER abandons the operation.
        issue(1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (16) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        held      = '{32'd0, 32'd0, 1'b0, 1'b0};
        idle_next = 1'b0;
        check_reset_state("mid_reset");
        mon_en = 1'b1;
        repeat (60) @(posedge clk);
        issue(1'b0, 32'd50, 32'd5);
        drain();

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'h8000_0000;
                4:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            issue(sg, a, b);
        end
        drain();

        chk("scoreboard_empty", 66'(sb.size()), 66'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
